// File: rtl/ob_pkg.sv
// Shared constants and FSM encoding for the price-level order book.
package ob_pkg;

    localparam int OB_DEPTH   = 8;
    localparam int OB_PRICE_W = 64;
    localparam int OB_QTY_W   = 64;

    localparam logic MSG_ADD    = 1'b0;
    localparam logic MSG_CANCEL = 1'b1;
    localparam logic SIDE_BID   = 1'b0;
    localparam logic SIDE_ASK   = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FIND,
        ST_APPLY,
        ST_PUBLISH
    } ob_state_t;

endpackage

// File: rtl/order_book_levels_if.sv
// Decoded FIX message stream into the order book; in_ready flows back to the decoder.
interface order_book_levels_if
    import ob_pkg::*;
#(
    parameter int PRICE_W = OB_PRICE_W,
    parameter int QTY_W   = OB_QTY_W
);
    logic               msg_valid;
    logic               msg_type;
    logic [47:0]        symbol_id;
    logic               side;
    logic [PRICE_W-1:0] price;
    logic [QTY_W-1:0]   quantity;
    logic [31:0]        order_id;
    logic               in_ready;

    modport master (
        output msg_valid, msg_type, symbol_id, side, price, quantity, order_id,
        input  in_ready
    );

    modport slave (
        input  msg_valid, msg_type, symbol_id, side, price, quantity, order_id,
        output in_ready
    );
endinterface

// File: rtl/order_book_levels_side_levels.sv
// One side of the book: DEPTH sorted aggregated levels, contiguous from index 0.
// DESCENDING=1 for bids (best = highest), 0 for asks (best = lowest).
module ob_side_levels
    import ob_pkg::*;
#(
    parameter int DEPTH      = OB_DEPTH,
    parameter int PRICE_W    = OB_PRICE_W,
    parameter int QTY_W      = OB_QTY_W,
    parameter bit DESCENDING = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               find_en,
    input  logic               apply_en,
    input  logic               op_type,
    input  logic [PRICE_W-1:0] price,
    input  logic [QTY_W-1:0]   quantity,
    output logic               hit,
    output logic               ins_ok,
    output logic               top_vld,
    output logic [PRICE_W-1:0] top_px,
    output logic [QTY_W-1:0]   top_qty
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]   vld;
    logic [PRICE_W-1:0] px  [DEPTH];
    logic [QTY_W-1:0]   qty [DEPTH];

    logic [IDX_W-1:0] hit_idx, ins_idx;
    logic [IDX_W-1:0] f_hit_idx, f_ins_idx;
    logic             f_hit, f_ins_ok;
    logic [QTY_W:0]   sum;
    logic [QTY_W-1:0] sat_sum;

    // Scan from the bottom so the lowest matching index wins.
    always_comb begin
        f_hit     = 1'b0;
        f_hit_idx = '0;
        f_ins_ok  = 1'b0;
        f_ins_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vld[i] && px[i] == price) begin
                f_hit     = 1'b1;
                f_hit_idx = IDX_W'(i);
            end
            if (!vld[i] || (DESCENDING ? (price > px[i]) : (price < px[i]))) begin
                f_ins_ok  = 1'b1;
                f_ins_idx = IDX_W'(i);
            end
        end
    end

    assign sum     = {1'b0, qty[hit_idx]} + {1'b0, quantity};
    assign sat_sum = sum[QTY_W] ? '1 : sum[QTY_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld     <= '0;
            hit     <= 1'b0;
            ins_ok  <= 1'b0;
            hit_idx <= '0;
            ins_idx <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                px[i]  <= '0;
                qty[i] <= '0;
            end
        end else begin
            if (find_en) begin
                hit     <= f_hit;
                hit_idx <= f_hit_idx;
                ins_ok  <= f_ins_ok;
                ins_idx <= f_ins_idx;
            end
            if (apply_en) begin
                if (op_type == MSG_ADD) begin
                    if (hit) begin
                        qty[hit_idx] <= sat_sum;
                    end else if (ins_ok) begin
                        for (int i = 1; i < DEPTH; i++) begin
                            if (i > int'(ins_idx)) begin
                                vld[i] <= vld[i-1];
                                px[i]  <= px[i-1];
                                qty[i] <= qty[i-1];
                            end
                        end
                        vld[ins_idx] <= 1'b1;
                        px[ins_idx]  <= price;
                        qty[ins_idx] <= quantity;
                    end
                end else if (hit) begin
                    if (quantity < qty[hit_idx]) begin
                        qty[hit_idx] <= qty[hit_idx] - quantity;
                    end else begin
                        for (int i = 0; i < DEPTH - 1; i++) begin
                            if (i >= int'(hit_idx)) begin
                                vld[i] <= vld[i+1];
                                px[i]  <= px[i+1];
                                qty[i] <= qty[i+1];
                            end
                        end
                        // Vacated slots hold zeros so shifted-in empty levels stay clean.
                        vld[DEPTH-1] <= 1'b0;
                        px[DEPTH-1]  <= '0;
                        qty[DEPTH-1] <= '0;
                    end
                end
            end
        end
    end

    assign top_vld = vld[0];
    assign top_px  = vld[0] ? px[0]  : '0;
    assign top_qty = vld[0] ? qty[0] : '0;
endmodule

// File: rtl/order_book_levels.sv
// Price-level order book with registered top-of-book; OB_SYMBOL_FILTER_EN restricts input to SYMBOL_ID.
// state   | meaning: IDLE wait msg | FIND compare levels | APPLY update side | PUBLISH register best_*
module order_book_levels
    import ob_pkg::*;
#(
    parameter int          DEPTH     = OB_DEPTH,
    parameter int          PRICE_W   = OB_PRICE_W,
    parameter int          QTY_W     = OB_QTY_W,
    parameter logic [47:0] SYMBOL_ID = 48'h0
) (
    input  logic               clk,
    input  logic               rst,
    order_book_levels_if.slave msg,
    output logic               best_bid_vld,
    output logic [PRICE_W-1:0] best_bid_px,
    output logic [QTY_W-1:0]   best_bid_qty,
    output logic               best_ask_vld,
    output logic [PRICE_W-1:0] best_ask_px,
    output logic [QTY_W-1:0]   best_ask_qty,
    output logic               tob_update,
    output logic               crossed,
    output logic [15:0]        drop_cnt,
    output logic               evt_full_drop,
    output logic               evt_cancel_miss
);
    ob_state_t          state;
    logic               in_ready_q;
    logic               typ_q, side_q;
    logic [PRICE_W-1:0] px_q;
    logic [QTY_W-1:0]   qty_q;
    logic               sym_ok;
    logic               unused_in;

`ifdef OB_SYMBOL_FILTER_EN
    assign sym_ok    = (msg.symbol_id == SYMBOL_ID);
    assign unused_in = ^msg.order_id;
`else
    assign sym_ok    = 1'b1;
    assign unused_in = ^{msg.order_id, msg.symbol_id, SYMBOL_ID};
`endif

    logic               bid_hit, bid_ins_ok, bid_vld, ask_hit, ask_ins_ok, ask_vld;
    logic [PRICE_W-1:0] bid_px, ask_px;
    logic [QTY_W-1:0]   bid_qty, ask_qty;
    logic               find_en, apply_en, sel_hit, sel_ins_ok;

    assign find_en    = (state == ST_FIND);
    assign apply_en   = (state == ST_APPLY);
    assign sel_hit    = (side_q == SIDE_ASK) ? ask_hit    : bid_hit;
    assign sel_ins_ok = (side_q == SIDE_ASK) ? ask_ins_ok : bid_ins_ok;

    ob_side_levels #(.DEPTH(DEPTH), .PRICE_W(PRICE_W), .QTY_W(QTY_W), .DESCENDING(1'b1)) u_bid (
        .clk, .rst, .find_en,
        .apply_en(apply_en && side_q == SIDE_BID),
        .op_type(typ_q), .price(px_q), .quantity(qty_q),
        .hit(bid_hit), .ins_ok(bid_ins_ok),
        .top_vld(bid_vld), .top_px(bid_px), .top_qty(bid_qty)
    );

    ob_side_levels #(.DEPTH(DEPTH), .PRICE_W(PRICE_W), .QTY_W(QTY_W), .DESCENDING(1'b0)) u_ask (
        .clk, .rst, .find_en,
        .apply_en(apply_en && side_q == SIDE_ASK),
        .op_type(typ_q), .price(px_q), .quantity(qty_q),
        .hit(ask_hit), .ins_ok(ask_ins_ok),
        .top_vld(ask_vld), .top_px(ask_px), .top_qty(ask_qty)
    );

    assign msg.in_ready = in_ready_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            in_ready_q      <= 1'b1;
            typ_q           <= 1'b0;
            side_q          <= 1'b0;
            px_q            <= '0;
            qty_q           <= '0;
            best_bid_vld    <= 1'b0;
            best_bid_px     <= '0;
            best_bid_qty    <= '0;
            best_ask_vld    <= 1'b0;
            best_ask_px     <= '0;
            best_ask_qty    <= '0;
            tob_update      <= 1'b0;
            crossed         <= 1'b0;
            drop_cnt        <= '0;
            evt_full_drop   <= 1'b0;
            evt_cancel_miss <= 1'b0;
        end else begin
            tob_update      <= 1'b0;
            evt_full_drop   <= 1'b0;
            evt_cancel_miss <= 1'b0;
            if (msg.msg_valid && !in_ready_q && sym_ok && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            case (state)
                ST_IDLE: begin
                    // Zero-quantity messages are consumed without touching the book.
                    if (msg.msg_valid && sym_ok && msg.quantity != '0) begin
                        typ_q      <= msg.msg_type;
                        side_q     <= msg.side;
                        px_q       <= msg.price;
                        qty_q      <= msg.quantity;
                        in_ready_q <= 1'b0;
                        state      <= ST_FIND;
                    end
                end
                ST_FIND: state <= ST_APPLY;
                ST_APPLY: begin
                    evt_full_drop   <= (typ_q == MSG_ADD) && !sel_hit && !sel_ins_ok;
                    evt_cancel_miss <= (typ_q == MSG_CANCEL) && !sel_hit;
                    state           <= ST_PUBLISH;
                end
                ST_PUBLISH: begin
                    best_bid_vld <= bid_vld;
                    best_bid_px  <= bid_px;
                    best_bid_qty <= bid_qty;
                    best_ask_vld <= ask_vld;
                    best_ask_px  <= ask_px;
                    best_ask_qty <= ask_qty;
                    tob_update   <= {bid_vld, bid_px, bid_qty, ask_vld, ask_px, ask_qty} !=
                                    {best_bid_vld, best_bid_px, best_bid_qty,
                                     best_ask_vld, best_ask_px, best_ask_qty};
                    crossed      <= bid_vld && ask_vld && (bid_px >= ask_px);
                    in_ready_q   <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_order_book_levels.sv
// Bench for order_book_levels: directed vector table, drop/reset sequences, random vs. queue model.
module tb_order_book_levels;
    import ob_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    order_book_levels_if #(.PRICE_W(64), .QTY_W(64)) mif ();

    logic        best_bid_vld, best_ask_vld, tob_update, crossed, evt_full_drop, evt_cancel_miss;
    logic [63:0] best_bid_px, best_bid_qty, best_ask_px, best_ask_qty;
    logic [15:0] drop_cnt;

    order_book_levels #(.DEPTH(DEPTH), .PRICE_W(64), .QTY_W(64), .SYMBOL_ID(48'h0)) dut (
        .clk(clk), .rst(rst), .msg(mif),
        .best_bid_vld(best_bid_vld), .best_bid_px(best_bid_px), .best_bid_qty(best_bid_qty),
        .best_ask_vld(best_ask_vld), .best_ask_px(best_ask_px), .best_ask_qty(best_ask_qty),
        .tob_update(tob_update), .crossed(crossed), .drop_cnt(drop_cnt),
        .evt_full_drop(evt_full_drop), .evt_cancel_miss(evt_cancel_miss)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference book: per side a sorted queue of (price, qty), best first.
    logic [63:0] mpx [2][$];
    logic [63:0] mq  [2][$];

    function automatic bit beats(input int si, input logic [63:0] a, input logic [63:0] b);
        return (si == 1) ? (a < b) : (a > b);
    endfunction

    task automatic model_apply(input logic typ, input logic sd, input logic [63:0] px,
                               input logic [63:0] qty, output int fd, output int cm);
        int si, h, pos;
        logic [63:0] s;
        fd = 0; cm = 0;
        si = int'(sd);
        if (qty == 0) return;
        h = -1;
        for (int i = 0; i < mpx[si].size(); i++) if (mpx[si][i] == px) h = i;
        if (typ == MSG_ADD) begin
            if (h >= 0) begin
                s = mq[si][h] + qty;
                if (s < mq[si][h]) s = '1;
                mq[si][h] = s;
            end else begin
                pos = mpx[si].size();
                for (int i = mpx[si].size() - 1; i >= 0; i--) if (beats(si, px, mpx[si][i])) pos = i;
                if (pos < DEPTH) begin
                    mpx[si].insert(pos, px);
                    mq[si].insert(pos, qty);
                    if (mpx[si].size() > DEPTH) begin
                        void'(mpx[si].pop_back());
                        void'(mq[si].pop_back());
                    end
                end else fd = 1;
            end
        end else begin
            if (h < 0) cm = 1;
            else if (qty >= mq[si][h]) begin
                mpx[si].delete(h);
                mq[si].delete(h);
            end else mq[si][h] = mq[si][h] - qty;
        end
    endtask

    task automatic model_best(input int si, output logic v, output logic [63:0] p, output logic [63:0] q);
        v = mpx[si].size() > 0;
        p = v ? mpx[si][0] : 64'd0;
        q = v ? mq[si][0]  : 64'd0;
    endtask

    task automatic idle_inputs();
        mif.msg_valid = 1'b0; mif.msg_type = 1'b0; mif.symbol_id = 48'h0; mif.side = 1'b0;
        mif.price = '0; mif.quantity = '0; mif.order_id = '0;
    endtask

    // Drive one message and observe four cycles; returns pulse counts seen.
    task automatic send(input logic typ, input logic sd, input logic [63:0] px, input logic [63:0] qty,
                        output int n_tob, output int n_fd, output int n_cm);
        int w;
        w = 0;
        while (!mif.in_ready && w < 50) begin @(negedge clk); w++; end
        if (!mif.in_ready) chk("in_ready_wait", {63'd0, mif.in_ready}, 64'd1);
        mif.msg_valid = 1'b1; mif.msg_type = typ; mif.side = sd; mif.price = px; mif.quantity = qty;
        mif.order_id = $urandom;
        n_tob = 0; n_fd = 0; n_cm = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) mif.msg_valid = 1'b0;
            n_tob += int'(tob_update);
            n_fd  += int'(evt_full_drop);
            n_cm  += int'(evt_cancel_miss);
        end
    endtask

    typedef struct {
        logic typ; logic sd; logic [63:0] px; logic [63:0] qty;
        logic bv; logic [63:0] bpx; logic [63:0] bq;
        logic av; logic [63:0] apx; logic [63:0] aq;
        logic cx; int tob; int fd; int cm;
    } vec_t;
    vec_t vecs[$];

    task automatic pv(input logic typ, input logic sd, input logic [63:0] px, input logic [63:0] qty,
                      input logic bv, input logic [63:0] bpx, input logic [63:0] bq,
                      input logic av, input logic [63:0] apx, input logic [63:0] aq,
                      input logic cx, input int tob, input int fd, input int cm);
        vec_t v;
        v.typ = typ; v.sd = sd; v.px = px; v.qty = qty; v.bv = bv; v.bpx = bpx; v.bq = bq;
        v.av = av; v.apx = apx; v.aq = aq; v.cx = cx; v.tob = tob; v.fd = fd; v.cm = cm;
        vecs.push_back(v);
    endtask

    task automatic check_book(input string tag, input logic bv, input logic [63:0] bpx, input logic [63:0] bq,
                              input logic av, input logic [63:0] apx, input logic [63:0] aq, input logic cx);
        chk({tag, " bid_vld"}, {63'd0, best_bid_vld}, {63'd0, bv});
        chk({tag, " bid_px"},  best_bid_px,  bpx);
        chk({tag, " bid_qty"}, best_bid_qty, bq);
        chk({tag, " ask_vld"}, {63'd0, best_ask_vld}, {63'd0, av});
        chk({tag, " ask_px"},  best_ask_px,  apx);
        chk({tag, " ask_qty"}, best_ask_qty, aq);
        chk({tag, " crossed"}, {63'd0, crossed}, {63'd0, cx});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt, nf, nc, mfd, mcm;
        logic bv, av, typ, sd;
        logic [63:0] bpx, bq, apx, aq, px, qty;
        logic [63:0] pre_b, pre_a;
        logic pre_bv, pre_av;
        logic [63:0] pre_bq, pre_aq;
        int r;

        idle_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset in_ready", {63'd0, mif.in_ready}, 64'd1);
        chk("reset drop_cnt", {48'd0, drop_cnt}, 64'd0);
        chk("reset tob_update", {63'd0, tob_update}, 64'd0);
        check_book("reset", 0, 0, 0, 0, 0, 0, 0);

        pv(MSG_ADD,    SIDE_BID, 100, 10, 1, 100, 10, 0, 0, 0, 0, 1, 0, 0);
        pv(MSG_ADD,    SIDE_BID, 102, 10, 1, 102, 10, 0, 0, 0, 0, 1, 0, 0);
        pv(MSG_ADD,    SIDE_BID, 101, 10, 1, 102, 10, 0, 0, 0, 0, 0, 0, 0);
        pv(MSG_ADD,    SIDE_BID, 102,  5, 1, 102, 15, 0, 0, 0, 0, 1, 0, 0);
        pv(MSG_CANCEL, SIDE_BID, 102, 15, 1, 101, 10, 0, 0, 0, 0, 1, 0, 0);
        pv(MSG_ADD,    SIDE_ASK, 200,  1, 1, 101, 10, 1, 200, 1, 0, 1, 0, 0);
        for (int p = 201; p <= 207; p++)
            pv(MSG_ADD, SIDE_ASK, 64'(p), 1, 1, 101, 10, 1, 200, 1, 0, 0, 0, 0);
        pv(MSG_ADD,    SIDE_ASK, 208,   1, 1, 101, 10, 1, 200, 1, 0, 0, 1, 0);
        pv(MSG_ADD,    SIDE_ASK, 199,   1, 1, 101, 10, 1, 199, 1, 0, 1, 0, 0);
        pv(MSG_ADD,    SIDE_BID, 300,   1, 1, 300,  1, 1, 199, 1, 1, 1, 0, 0);
        pv(MSG_CANCEL, SIDE_ASK, 199, 999, 1, 300,  1, 1, 200, 1, 1, 1, 0, 0);
        pv(MSG_CANCEL, SIDE_BID, 555,   1, 1, 300,  1, 1, 200, 1, 1, 0, 0, 1);
        pv(MSG_ADD,    SIDE_BID,  50,   0, 1, 300,  1, 1, 200, 1, 1, 0, 0, 0);
        pv(MSG_CANCEL, SIDE_ASK, 207,   1, 1, 300,  1, 1, 200, 1, 1, 0, 0, 1);
        pv(MSG_CANCEL, SIDE_ASK, 206,   1, 1, 300,  1, 1, 200, 1, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            send(vecs[i].typ, vecs[i].sd, vecs[i].px, vecs[i].qty, nt, nf, nc);
            model_apply(vecs[i].typ, vecs[i].sd, vecs[i].px, vecs[i].qty, mfd, mcm);
            check_book(tag, vecs[i].bv, vecs[i].bpx, vecs[i].bq, vecs[i].av, vecs[i].apx, vecs[i].aq, vecs[i].cx);
            chk({tag, " tob_pulses"}, 64'(nt), 64'(vecs[i].tob));
            chk({tag, " full_drop"},  64'(nf), 64'(vecs[i].fd));
            chk({tag, " cancel_miss"}, 64'(nc), 64'(vecs[i].cm));
        end

        // Three back-to-back strobes: first taken, the next two counted as drops.
        mif.msg_valid = 1'b1; mif.msg_type = MSG_ADD; mif.side = SIDE_BID; mif.price = 400; mif.quantity = 1;
        @(negedge clk);
        chk("busy in_ready", {63'd0, mif.in_ready}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        mif.msg_valid = 1'b0;
        repeat (2) @(negedge clk);
        model_apply(MSG_ADD, SIDE_BID, 400, 1, mfd, mcm);
        chk("drop_cnt", {48'd0, drop_cnt}, 64'd2);
        chk("drop bid_px", best_bid_px, 64'd400);

`ifdef OB_SYMBOL_FILTER_EN
        mif.symbol_id = 48'h1;
        send(MSG_ADD, SIDE_BID, 450, 1, nt, nf, nc);
        mif.symbol_id = 48'h0;
        chk("foreign bid_px", best_bid_px, 64'd400);
        chk("foreign drop_cnt", {48'd0, drop_cnt}, 64'd2);
        chk("foreign tob", 64'(nt), 64'd0);
`endif

        // Reset while a message is in flight.
        mif.msg_valid = 1'b1; mif.msg_type = MSG_ADD; mif.side = SIDE_ASK; mif.price = 150; mif.quantity = 3;
        @(negedge clk);
        mif.msg_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset drop_cnt", {48'd0, drop_cnt}, 64'd0);
        chk("midreset tob", {63'd0, tob_update}, 64'd0);
        check_book("midreset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset in_ready", {63'd0, mif.in_ready}, 64'd1);
        for (int s = 0; s < 2; s++) begin mpx[s].delete(); mq[s].delete(); end

        for (int it = 0; it < 300; it++) begin
            string tag;
            tag = $sformatf("rnd%0d", it);
            typ = ($urandom_range(0, 2) == 0) ? MSG_CANCEL : MSG_ADD;
            sd  = 1'($urandom_range(0, 1));
            px  = sd ? 64'(100 + $urandom_range(0, 15)) : 64'(90 + $urandom_range(0, 15));
            r   = $urandom_range(0, 31);
            if (r == 0)      qty = 0;
            else if (r == 1) qty = 64'hFFFF_FFFF_FFFF_FFF0;
            else             qty = 64'($urandom_range(1, 30));
            model_best(0, pre_bv, pre_b, pre_bq);
            model_best(1, pre_av, pre_a, pre_aq);
            send(typ, sd, px, qty, nt, nf, nc);
            model_apply(typ, sd, px, qty, mfd, mcm);
            model_best(0, bv, bpx, bq);
            model_best(1, av, apx, aq);
            check_book(tag, bv, bpx, bq, av, apx, aq, bv && av && (bpx >= apx));
            chk({tag, " tob_pulses"}, 64'(nt),
                64'(({pre_bv, pre_b, pre_bq, pre_av, pre_a, pre_aq} != {bv, bpx, bq, av, apx, aq}) ? 1 : 0));
            chk({tag, " full_drop"}, 64'(nf), 64'(mfd));
            chk({tag, " cancel_miss"}, 64'(nc), 64'(mcm));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
